hazard_ctrl_mc: RTL and testbench

Parametrised pipeline hazard controller for the five-stage RISC-V core. It supersedes the purely combinational hazard unit and adds multi-cycle support:

- M/W forwarding into Execute, generalised in register-address width.
- Load-use stalls of configurable length.
- Stalls for a multi-cycle execute unit (MUL/DIV) and for a data memory that can hold off via a ready handshake.
- Branch flushes.
- A saturating stall-cycle counter for performance monitoring.

It sits beside the datapath and drives the stall/flush enables of every pipeline register.

---
 rtl/hazard_ctrl_mc.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the five-stage core: M/W forwarding, load-use,
// multi-cycle execute and data-memory wait stalls, branch flushes, stall counter.
module hazard_ctrl_mc #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int STALL_CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  Rs1D,
    input  logic [REG_ADDR_W-1:0]  Rs2D,
    input  logic [REG_ADDR_W-1:0]  Rs1E,
    input  logic [REG_ADDR_W-1:0]  Rs2E,
    input  logic [REG_ADDR_W-1:0]  RdE,
    input  logic [REG_ADDR_W-1:0]  RdM,
    input  logic [REG_ADDR_W-1:0]  RdW,
    input  logic                   ResultSrcEb2,
    input  logic                   PCSrcE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   McBusyE,
    input  logic                   MemReqM,
    input  logic                   MemReadyM,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   StallM,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushM,
    output logic                   FlushW,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic [STALL_CNT_W-1:0] StallCnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MC_WAIT    = 2'd2,
        MEM_WAIT   = 2'd3
    } stateT;

    localparam logic [3:0] LD_INIT = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
    localparam bit MULTI_LOAD_STALL = (LOAD_STALL_CYCLES > 1);

    stateT      state, stateNext;
    logic [3:0] LdCnt, LdCntNext;
    logic       LdPend, LdPendNext;

    logic memHaz;
    logic mcHaz;
    logic newLoadUse;

    assign memHaz     = MemReqM & ~MemReadyM;
    assign mcHaz      = McBusyE;
    assign newLoadUse = ResultSrcEb2 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

    // LdPend marks a multi-cycle load stall still in progress; it survives a
    // mem/mc preemption so the stall resumes from the frozen LdCnt afterwards.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state  <= RUN;
            LdCnt  <= 4'd0;
            LdPend <= 1'b0;
        end else begin
            state  <= stateNext;
            LdCnt  <= LdCntNext;
            LdPend <= LdPendNext;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the priority chain can infer a latch.
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        FlushW     = 1'b0;
        stateNext  = RUN;
        LdCntNext  = LdCnt;
        LdPendNext = LdPend;

        if (!reset) begin
            FlushD     = 1'b1;
            FlushE     = 1'b1;
            FlushM     = 1'b1;
            FlushW     = 1'b1;
            LdCntNext  = 4'd0;
            LdPendNext = 1'b0;
        end else if (memHaz) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            StallM    = 1'b1;
            FlushW    = 1'b1;
            stateNext = MEM_WAIT;
        end else if (mcHaz) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            FlushM    = 1'b1;
            stateNext = MC_WAIT;
        end else if (PCSrcE) begin
            // The branch squashes the dependent instruction, so any load stall is moot.
            FlushD     = 1'b1;
            FlushE     = 1'b1;
            LdCntNext  = 4'd0;
            LdPendNext = 1'b0;
        end else if (LdPend) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            if (LdCnt == 4'd0) begin
                LdPendNext = 1'b0;
            end else begin
                LdCntNext = LdCnt - 4'd1;
                stateNext = LOAD_STALL;
            end
        end else if (newLoadUse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            if (MULTI_LOAD_STALL) begin
                LdCntNext  = LD_INIT;
                LdPendNext = 1'b1;
                stateNext  = LOAD_STALL;
            end
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            if ((Rs1E != '0) && RegWriteM && (Rs1E == RdM)) begin
                ForwardAE = 2'b10;
            end else if ((Rs1E != '0) && RegWriteW && (Rs1E == RdW)) begin
                ForwardAE = 2'b01;
            end
            if ((Rs2E != '0) && RegWriteM && (Rs2E == RdM)) begin
                ForwardBE = 2'b10;
            end else if ((Rs2E != '0) && RegWriteW && (Rs2E == RdW)) begin
                ForwardBE = 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            StallCnt <= '0;
        end else if (StallF && (StallCnt != '1)) begin
            StallCnt <= StallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: directed hazard scenarios plus random
// stimulus against a cycle-level reference model, on two parameterisations.
module tb_hazard_ctrl_mc;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcEb2, PCSrcE, RegWriteM, RegWriteW, McBusyE, MemReqM, MemReadyM;

    logic        StallFA, StallDA, StallEA, StallMA, FlushDA, FlushEA, FlushMA, FlushWA;
    logic [1:0]  ForwardAEA, ForwardBEA;
    logic [31:0] StallCntA;
    logic        StallFB, StallDB, StallEB, StallMB, FlushDB, FlushEB, FlushMB, FlushWB;
    logic [1:0]  ForwardAEB, ForwardBEB;
    logic [1:0]  StallCntB;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state: remaining load-stall cycles and stall-cycle counts.
    int     remA, remB;
    longint cntA, cntB;
    int     stallSeenA, stallMSeenA;

    hazard_ctrl_mc #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .STALL_CNT_W(32)) uA (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcEb2(ResultSrcEb2), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .McBusyE(McBusyE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallFA), .StallD(StallDA), .StallE(StallEA), .StallM(StallMA),
        .FlushD(FlushDA), .FlushE(FlushEA), .FlushM(FlushMA), .FlushW(FlushWA),
        .ForwardAE(ForwardAEA), .ForwardBE(ForwardBEA), .StallCnt(StallCntA)
    );

    hazard_ctrl_mc #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .STALL_CNT_W(2)) uB (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcEb2(ResultSrcEb2), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .McBusyE(McBusyE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallFB), .StallD(StallDB), .StallE(StallEB), .StallM(StallMB),
        .FlushD(FlushDB), .FlushE(FlushEB), .FlushM(FlushMB), .FlushW(FlushWB),
        .ForwardAE(ForwardAEB), .ForwardBE(ForwardBEB), .StallCnt(StallCntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected stall {F,D,E,M} and flush {D,E,M,W} from the hazard priority rules;
    // rem counts load-stall cycles still owed, L is the configured stall length.
    task automatic modelEval(input int L, input int rem, output logic [3:0] stall,
                             output logic [3:0] flush, output int remNext);
        stall   = 4'b0000;
        flush   = 4'b0000;
        remNext = rem;
        if (!reset) begin
            flush   = 4'b1111;
            remNext = 0;
        end else if (MemReqM && !MemReadyM) begin
            stall = 4'b1111;
            flush = 4'b0001;
        end else if (McBusyE) begin
            stall = 4'b1110;
            flush = 4'b0010;
        end else if (PCSrcE) begin
            flush   = 4'b1100;
            remNext = 0;
        end else if (rem > 0) begin
            stall   = 4'b1100;
            flush   = 4'b0100;
            remNext = rem - 1;
        end else if (ResultSrcEb2 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE)) begin
            stall   = 4'b1100;
            flush   = 4'b0100;
            remNext = L - 1;
        end
    endtask

    function automatic logic [1:0] fwdModel(input logic [4:0] rs);
        if (!reset || rs == 0) return 2'b00;
        if (RegWriteM && rs == RdM) return 2'b10;
        if (RegWriteW && rs == RdW) return 2'b01;
        return 2'b00;
    endfunction

    // One cycle: compare outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        logic [3:0] sA, fA, sB, fB;
        int nA, nB;
        @(negedge clk);
        modelEval(3, remA, sA, fA, nA);
        modelEval(1, remB, sB, fB, nB);
        check("stallA", 32'({StallFA, StallDA, StallEA, StallMA}), 32'(sA));
        check("flushA", 32'({FlushDA, FlushEA, FlushMA, FlushWA}), 32'(fA));
        check("fwdA",   32'({ForwardAEA, ForwardBEA}), 32'({fwdModel(Rs1E), fwdModel(Rs2E)}));
        check("cntA",   StallCntA, 32'(cntA));
        check("stallB", 32'({StallFB, StallDB, StallEB, StallMB}), 32'(sB));
        check("flushB", 32'({FlushDB, FlushEB, FlushMB, FlushWB}), 32'(fB));
        check("fwdB",   32'({ForwardAEB, ForwardBEB}), 32'({fwdModel(Rs1E), fwdModel(Rs2E)}));
        check("cntB",   32'(StallCntB), 32'(cntB));
        stallSeenA  += int'(StallFA);
        stallMSeenA += int'(StallMA);
        remA = nA;
        remB = nB;
        if (!reset) begin
            cntA = 0;
            cntB = 0;
        end else begin
            if (sA[3] && cntA < 64'hFFFF_FFFF) cntA++;
            if (sB[3] && cntB < 3) cntB++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {ResultSrcEb2, PCSrcE, RegWriteM, RegWriteW, McBusyE, MemReqM, MemReadyM} = '0;
    endtask

    initial begin
        logic [31:0] cntBefore;
        idle();
        reset = 1'b0;
        remA = 0; remB = 0; cntA = 0; cntB = 0;
        stallSeenA = 0; stallMSeenA = 0;
        @(posedge clk);
        #1;

        // Reset overrides every hazard and forwarding match.
        {MemReqM, McBusyE, PCSrcE, ResultSrcEb2, RegWriteM, RegWriteW} = '1;
        {Rs1E, Rs2E, RdM, RdW, RdE, Rs1D} = {6{5'd5}};
        step();
        step();

        // Forwarding priority on both operands.
        for (int op = 0; op < 2; op++) begin
            idle();
            RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd5; RdW = 5'd5;
            if (op == 0) Rs1E = 5'd5; else Rs2E = 5'd5;
            step();
            RegWriteM = 1'b0;
            step();
            if (op == 0) Rs1E = 5'd0; else Rs2E = 5'd0;
            step();
        end

        // Load-use: exactly three stall cycles on the L=3 instance.
        idle();
        stallSeenA = 0;
        cntBefore = StallCntA;
        ResultSrcEb2 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        step();
        idle();
        repeat (4) step();
        check("ldStallLen", 32'(stallSeenA), 32'd3);
        check("ldCntDelta", StallCntA - cntBefore, 32'd3);

        // Load into x0 never stalls.
        stallSeenA = 0;
        ResultSrcEb2 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        step();
        check("x0NoStall", 32'(stallSeenA), 32'd0);

        // Branch and load-use together: branch wins.
        idle();
        stallSeenA = 0;
        PCSrcE = 1'b1; ResultSrcEb2 = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
        step();
        idle();
        step();
        check("brNoStall", 32'(stallSeenA), 32'd0);

        // Multi-cycle op for five cycles, branch ignored meanwhile.
        stallSeenA = 0;
        cntBefore = StallCntA;
        McBusyE = 1'b1; PCSrcE = 1'b1;
        repeat (5) step();
        idle();
        step();
        check("mcStallLen", 32'(stallSeenA), 32'd5);
        check("mcCntDelta", StallCntA - cntBefore, 32'd5);

        // Memory wait preempts a load stall in its second cycle; the stall resumes.
        stallSeenA = 0; stallMSeenA = 0;
        ResultSrcEb2 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
        step();
        idle();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (4) step();
        MemReqM = 1'b0; MemReadyM = 1'b1;
        repeat (4) step();
        check("memStallM", 32'(stallMSeenA), 32'd4);
        check("memPreemptTotal", 32'(stallSeenA), 32'd7);

        // Reset in the middle of a multi-cycle wait, then counter saturation on B.
        idle();
        McBusyE = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        reset = 1'b1; McBusyE = 1'b0;
        step();
        check("cntAfterReset", StallCntA, 32'd0);
        McBusyE = 1'b1;
        repeat (6) step();
        check("satB", 32'(StallCntB), 32'd3);
        idle();
        step();

        // Exhaustive register-address forwarding sweep.
        for (int rd = 0; rd < 32; rd++) begin
            for (int rs = 0; rs < 32; rs++) begin
                RdM = 5'(rd); RdW = 5'($urandom_range(0, 31));
                Rs1E = 5'(rs); Rs2E = 5'(31 - rs);
                RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
                if (rs[2]) RdW = 5'(rs);
                step();
            end
        end

        // Random traffic, addresses biased toward a few registers to provoke hazards.
        repeat (3000) begin
            reset        = ($urandom_range(0, 63) != 0);
            Rs1D         = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            Rs2D         = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            Rs1E         = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            Rs2E         = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            RdE          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            RdM          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            RdW          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            ResultSrcEb2 = ($urandom_range(0, 2) == 0);
            PCSrcE       = ($urandom_range(0, 7) == 0);
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            McBusyE      = ($urandom_range(0, 5) == 0);
            MemReqM      = ($urandom_range(0, 5) == 0);
            MemReadyM    = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
